// File: rtl/pirdsp_pkg.sv
// pirdsp_pkg
// Shared definitions for the PIRDSP SIMD multiply-accumulate engine and its
// techmap wrappers: beat mode encoding and parameter legality checks.
package pirdsp_pkg;

  // Per-beat operation. The reserved code behaves as MUL.
  typedef enum logic [1:0] {
    MODE_MUL  = 2'b00,
    MODE_ACC  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int PIPE_MIN   = 1;
  localparam int PIPE_MAX   = 4;
  localparam int LANE_W_MIN = 4;
  localparam int LANE_W_MAX = 27;

  function automatic bit pipe_legal(input int pipe);
    return (pipe >= PIPE_MIN) && (pipe <= PIPE_MAX);
  endfunction

  function automatic bit lane_w_legal(input int lane_w);
    return (lane_w >= LANE_W_MIN) && (lane_w <= LANE_W_MAX);
  endfunction

  // The accumulator must hold a full-width product without truncation.
  function automatic bit acc_w_legal(input int acc_w, input int lane_w);
    return acc_w >= 2 * lane_w;
  endfunction

endpackage

// File: rtl/pirdsp_simd_lane.sv
// pirdsp_simd_lane
// One SIMD lane: multiply, product pipeline, output-stage accumulator and
// sticky overflow flag. All flow control comes from the parent as per-stage
// load enables; the lane holds no valid state of its own.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : lane operands (LANE_W bits)
//   en         : per-stage load enable, en[k] = a real beat enters stage k
//   acc        : the beat entering the output stage is an ACC beat
//   p          : lane result (ACC_W bits)
//   ovf        : sticky overflow flag
module pirdsp_simd_lane
  import pirdsp_pkg::*;
#(
  parameter int LANE_W = 9,
  parameter int ACC_W  = 22,
  parameter int SIGNED = 1,
  parameter int PIPE   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [PIPE-1:0]   en,
  input  logic              acc,
  output logic [ACC_W-1:0]  p,
  output logic              ovf
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] feed [PIPE];
  logic [ACC_W:0]   sum_next;
  logic             ovf_add;
  logic [ACC_W-1:0] p_reg;
  logic             ovf_reg;

  // Extending the operands to ACC_W before multiplying yields the product
  // already sign/zero-extended, since ACC_W >= 2*LANE_W.
  if (SIGNED != 0) begin : g_signed
    assign ext = ACC_W'($signed(a)) * ACC_W'($signed(b));
  end else begin : g_unsigned
    assign ext = ACC_W'(a) * ACC_W'(b);
  end

  // feed[k] is the data entering stage k; stage PIPE-1 is the output stage.
  assign feed[0] = ext;
  for (genvar gi = 1; gi < PIPE; gi++) begin : g_stage
    logic [ACC_W-1:0] prod_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_reg <= '0;
      end else if (en[gi-1]) begin
        prod_reg <= feed[gi-1];
      end
    end
    assign feed[gi] = prod_reg;
  end

  // Accumulate on entry to the output stage so ACC beats chain without a bubble.
  assign sum_next = {1'b0, p_reg} + {1'b0, feed[PIPE-1]};
  assign ovf_add  = (SIGNED != 0)
                  ? ((p_reg[ACC_W-1] == feed[PIPE-1][ACC_W-1]) &&
                     (sum_next[ACC_W-1] != p_reg[ACC_W-1]))
                  : sum_next[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (en[PIPE-1]) begin
      if (acc) begin
        p_reg   <= sum_next[ACC_W-1:0];
        ovf_reg <= ovf_reg | ovf_add;
      end else begin
        p_reg   <= feed[PIPE-1];
        ovf_reg <= 1'b0;
      end
    end
  end

  assign p   = p_reg;
  assign ovf = ovf_reg;

endmodule

// File: rtl/pirdsp_simd_mac.sv
// pirdsp_simd_mac
// Pipelined SIMD multiply-accumulate engine with valid/ready streaming and
// per-lane sticky overflow. Stage valids and the elastic load chain live
// here once; the lanes only see per-stage load enables.
//
// Ports:
//   CLK, RSTN            : clock, asynchronous active-low reset
//   IN_VALID, IN_READY   : input beat handshake
//   A, B                 : packed lane operands, lane i at [i*LANE_W +: LANE_W]
//   MODE                 : 00 MUL, 01 ACC, 10 LOAD, 11 reserved (MUL)
//   OUT_VALID, OUT_READY : output beat handshake
//   P                    : packed lane results, lane i at [i*ACC_W +: ACC_W]
//   OVF                  : per-lane sticky overflow flags
module pirdsp_simd_mac
  import pirdsp_pkg::*;
#(
  parameter int LANE_W = 9,
  parameter int LANES  = 6,
  parameter int ACC_W  = 22,
  parameter int SIGNED = 1,
  parameter int PIPE   = 2
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [LANES*LANE_W-1:0] A,
  input  logic [LANES*LANE_W-1:0] B,
  input  logic [1:0]              MODE,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [LANES*ACC_W-1:0]  P,
  output logic [LANES-1:0]        OVF
);

  if (!pipe_legal(PIPE)) begin : g_bad_pipe
    $error("pirdsp_simd_mac: PIPE must be in 1..4");
  end
  if (!lane_w_legal(LANE_W)) begin : g_bad_lane_w
    $error("pirdsp_simd_mac: LANE_W must be in 4..27");
  end
  if (!acc_w_legal(ACC_W, LANE_W)) begin : g_bad_acc_w
    $error("pirdsp_simd_mac: ACC_W must be at least 2*LANE_W");
  end

  logic [PIPE-1:0] vld_reg;
  logic [PIPE-1:0] src_vld;
  logic [PIPE-1:0] ld;
  logic [PIPE-1:0] en;
  mode_e           mode_feed [PIPE];
  logic            acc;

  // ld[k]: stage k takes whatever its source offers this cycle. A stage may
  // load when it is empty or when its own contents move on, so a full
  // pipeline with OUT_READY high still accepts a beat every cycle.
  always_comb begin
    src_vld    = '0;
    ld         = '0;
    src_vld[0] = IN_VALID;
    for (int k = 1; k < PIPE; k++) begin
      src_vld[k] = vld_reg[k-1];
    end
    ld[PIPE-1] = !vld_reg[PIPE-1] || OUT_READY;
    for (int k = PIPE - 2; k >= 0; k--) begin
      ld[k] = !vld_reg[k] || ld[k+1];
    end
    // Data registers only move on real beats, so P holds across bubbles and
    // the accumulator always sees the last written result.
    en = ld & src_vld;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= (vld_reg & ~ld) | (src_vld & ld);
    end
  end

  // Mode travels alongside the products; only the output stage consumes it.
  assign mode_feed[0] = mode_e'(MODE);
  for (genvar gi = 1; gi < PIPE; gi++) begin : g_mode
    mode_e mode_reg;
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        mode_reg <= MODE_MUL;
      end else if (en[gi-1]) begin
        mode_reg <= mode_feed[gi-1];
      end
    end
    assign mode_feed[gi] = mode_reg;
  end

  assign acc       = (mode_feed[PIPE-1] == MODE_ACC);
  assign IN_READY  = ld[0];
  assign OUT_VALID = vld_reg[PIPE-1];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    pirdsp_simd_lane #(
      .LANE_W(LANE_W),
      .ACC_W (ACC_W),
      .SIGNED(SIGNED),
      .PIPE  (PIPE)
    ) u_lane (
      .clk  (CLK),
      .rst_n(RSTN),
      .a    (A[gi*LANE_W +: LANE_W]),
      .b    (B[gi*LANE_W +: LANE_W]),
      .en   (en),
      .acc  (acc),
      .p    (P[gi*ACC_W +: ACC_W]),
      .ovf  (OVF[gi])
    );
  end

endmodule
